// File: rtl/cache_port_arbiter.sv
// Serialises NUM_PORTS independent 4-phase request/valid masters onto one 4-phase cache port.
// Round-robin or fixed-priority selection; sticky watchdog for a cache that never acknowledges.

module cache_port_arbiter_lane (
   input  logic clock,
   input  logic reset,
   input  logic set,
   input  logic clr,
   input  logic evict_in,
   output logic valid,
   output logic evict
);
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         evict <= 1'b0;
      end else if (set) begin
         valid <= 1'b1;
         evict <= evict_in;
      end else if (clr) begin
         valid <= 1'b0;
         evict <= 1'b0;
      end
   end
endmodule

module cache_port_arbiter #(
   parameter int NUM_PORTS    = 2,
   parameter int ADDRESSWIDTH = 32,
   parameter int DATAWIDTH    = 8,
   parameter int OPWIDTH      = 4,
   parameter int ARB_MODE     = 0,
   parameter int TIMEOUT      = 255
) (
   input  logic                                              clock,
   input  logic                                              reset,
   input  logic [NUM_PORTS*OPWIDTH-1:0]                      req_operation,
   input  logic [NUM_PORTS*ADDRESSWIDTH-1:0]                 req_addr,
   input  logic [NUM_PORTS*DATAWIDTH-1:0]                    req_wdata,
   input  logic [NUM_PORTS-1:0]                              req_request,
   output logic [NUM_PORTS-1:0]                              req_valid,
   output logic [NUM_PORTS-1:0]                              req_evict,
   output logic [DATAWIDTH-1:0]                              req_rdata,
   output logic [OPWIDTH-1:0]                                cache_operation,
   output logic [ADDRESSWIDTH-1:0]                           cache_addr,
   output logic [DATAWIDTH-1:0]                              cache_wdata,
   output logic                                              cache_request,
   input  logic                                              cache_valid,
   input  logic                                              cache_evict,
   input  logic [DATAWIDTH-1:0]                              cache_rdata,
   output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant,
   output logic                                              busy,
   output logic                                              timeout_err
);
   localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_VALID, WAIT_DROP, WAIT_RELEASE} state_t;

   state_t state, state_nxt;

   logic [NUM_PORTS-1:0][OPWIDTH-1:0]      op_v;
   logic [NUM_PORTS-1:0][ADDRESSWIDTH-1:0] addr_v;
   logic [NUM_PORTS-1:0][DATAWIDTH-1:0]    wdata_v;

   logic [GW-1:0] rr_ptr, rr_nxt, win, idx_b;
   logic          cur_req, take, ack, drop, rel;
   logic [CW-1:0] wd_cnt;
   int            idx;

   assign op_v    = req_operation;
   assign addr_v  = req_addr;
   assign wdata_v = req_wdata;
   assign cur_req = req_request[grant];
   assign busy    = (state != IDLE);
   assign rr_nxt  = GW'((int'(grant) + 1) % NUM_PORTS);

   // Scan from the highest rank down so the first-ranked requester is the last to overwrite win.
   always_comb begin
      win   = '0;
      idx   = 0;
      idx_b = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx   = (ARB_MODE != 0) ? k : (int'(rr_ptr) + k) % NUM_PORTS;
         idx_b = GW'(idx);
         if (req_request[idx_b]) win = idx_b;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      ack       = 1'b0;
      drop      = 1'b0;
      rel       = 1'b0;
      case (state)
         IDLE: begin
            if (|req_request) begin
               take      = 1'b1;
               state_nxt = WAIT_VALID;
            end
         end
         // A master dropping its request before valid is ignored here.
         WAIT_VALID: begin
            if (cache_valid) begin
               ack       = 1'b1;
               state_nxt = WAIT_DROP;
            end
         end
         WAIT_DROP: begin
            if (!cur_req) begin
               drop      = 1'b1;
               state_nxt = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (!cache_valid) begin
               rel       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cache_operation <= '0;
         cache_addr      <= '0;
         cache_wdata     <= '0;
         cache_request   <= 1'b0;
         grant           <= '0;
         rr_ptr          <= '0;
         req_rdata       <= '0;
      end else begin
         if (take) begin
            cache_operation <= op_v[win];
            cache_addr      <= addr_v[win];
            cache_wdata     <= wdata_v[win];
            grant           <= win;
            cache_request   <= 1'b1;
         end
         if (ack)  req_rdata     <= cache_rdata;
         if (drop) cache_request <= 1'b0;
         if (rel && ARB_MODE == 0) rr_ptr <= rr_nxt;
      end
   end

   // Counter holds the number of completed waiting cycles; the flag rises at the edge closing
   // the TIMEOUT-th waiting cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else if (take) begin
         wd_cnt <= '0;
      end else if (state == WAIT_VALID && !cache_valid) begin
         if (wd_cnt != {CW{1'b1}}) wd_cnt <= wd_cnt + 1'b1;
         if (TIMEOUT > 0 && int'(wd_cnt) + 1 >= TIMEOUT) timeout_err <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
      cache_port_arbiter_lane u_lane (
         .clock    (clock),
         .reset    (reset),
         .set      (ack && grant == GW'(i)),
         .clr      (rel && grant == GW'(i)),
         .evict_in (cache_evict),
         .valid    (req_valid[i]),
         .evict    (req_evict[i])
      );
   end
endmodule
